// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional alignment checking is enabled with the IFETCH_ALIGN_CHECK_EN macro.
package ifetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] CODE_START = 32'h8000;
    localparam logic [XLEN-1:0] PC_STEP    = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            fault;
    } ifq_entry_t;

    // Width of a counter that must hold values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/instr_fetch_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; used for both the
// instruction queue and the outstanding-PC FIFO of instr_fetch.
module sync_fifo
    import ifetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push into a full FIFO is legal only when a pop frees the slot this edge.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (!reset_n || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues PC-addressed reads under a credit rule, pairs
// in-order responses with their PCs and queues them for decode.
// IFETCH_ALIGN_CHECK_EN turns misaligned PCs into queued fetch faults.
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int XLEN    = ifetch_pkg::XLEN,
    parameter int QDEPTH  = 4,
    parameter int MAX_OUT = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_advance_o,
    input  logic            redirect_i,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [XLEN-1:0] mem_req_addr_o,
    input  logic            mem_rsp_valid_i,
    input  logic [XLEN-1:0] mem_rsp_data_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic            inst_fault_o
);

    localparam int QCW = cnt_w(QDEPTH);
    localparam int OCW = cnt_w(MAX_OUT);

    ifq_entry_t      q_push_data, q_head;
    logic [QCW-1:0]  q_cnt;
    logic [OCW-1:0]  out_cnt;
    logic [XLEN-1:0] pcf_head;
    logic [OCW-1:0]  drop_q, drop_d;
    logic [31:0]     credit_used;
    logic            base_ok, misalign, fault_pend, fault_push;
    logic            req_valid, req_fire;
    logic            rsp_live, rsp_owed;
    logic            q_push, q_pop, inst_valid;

    // Outstanding requests are exactly the PCs waiting in the PC FIFO.
    assign credit_used = 32'(out_cnt) + 32'(q_cnt);

    assign base_ok = reset_n && !redirect_i && (drop_q == '0) && !fault_pend
                  && (out_cnt < OCW'(MAX_OUT)) && (credit_used < 32'(QDEPTH));

`ifdef IFETCH_ALIGN_CHECK_EN
    logic fault_pend_q, fault_pend_d;

    assign misalign   = (pc_i[1:0] != 2'b00);
    // Wait for older fetches to drain so the fault lands behind them in order.
    assign fault_push = base_ok && misalign && (out_cnt == '0);

    always_comb begin
        fault_pend_d = fault_pend_q;
        if (redirect_i)      fault_pend_d = 1'b0;
        else if (fault_push) fault_pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) fault_pend_q <= 1'b0;
        else          fault_pend_q <= fault_pend_d;
    end

    assign fault_pend   = fault_pend_q;
    assign inst_fault_o = inst_valid && q_head.fault;
`else
    assign misalign     = 1'b0;
    assign fault_push   = 1'b0;
    assign fault_pend   = 1'b0;
    assign inst_fault_o = 1'b0;
`endif

    // Eligibility only shrinks on a redirect, so valid/addr hold until accepted.
    assign req_valid       = base_ok && !misalign;
    assign req_fire        = req_valid && mem_req_ready_i;
    assign mem_req_valid_o = req_valid;
    assign mem_req_addr_o  = pc_i;
    assign pc_advance_o    = req_fire;

    assign rsp_live = mem_rsp_valid_i && !redirect_i && (drop_q == '0) && (out_cnt != '0);
    assign rsp_owed = mem_rsp_valid_i && ((drop_q != '0) || (out_cnt != '0));

    // Responses still owed by memory at a redirect are counted off as stale.
    always_comb begin
        drop_d = drop_q;
        if (redirect_i)                             drop_d = drop_q + out_cnt - OCW'(rsp_owed);
        else if (mem_rsp_valid_i && drop_q != '0)   drop_d = drop_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) drop_q <= '0;
        else          drop_q <= drop_d;
    end

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUT)
    ) u_pc_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (redirect_i),
        .push_i  (req_fire),
        .data_i  (pc_i),
        .pop_i   (rsp_live),
        .data_o  (pcf_head),
        .count_o (out_cnt)
    );

    always_comb begin
        q_push_data = '{inst: mem_rsp_data_i, pc: pcf_head, fault: 1'b0};
        if (fault_push) q_push_data = '{inst: '0, pc: pc_i, fault: 1'b1};
    end

    assign q_push = rsp_live || fault_push;
    assign q_pop  = inst_valid && inst_ready_i && !redirect_i;

    sync_fifo #(
        .WIDTH ($bits(ifq_entry_t)),
        .DEPTH (QDEPTH)
    ) u_inst_q (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (redirect_i),
        .push_i  (q_push),
        .data_i  (q_push_data),
        .pop_i   (q_pop),
        .data_o  (q_head),
        .count_o (q_cnt)
    );

    assign inst_valid   = reset_n && (q_cnt != '0);
    assign inst_valid_o = inst_valid;
    assign inst_o       = inst_valid ? q_head.inst : '0;
    assign inst_pc_o    = inst_valid ? q_head.pc   : '0;

    // A response nobody asked for points at a broken memory model.
    rsp_orphan_a: assert property (@(posedge clk) disable iff (!reset_n)
        !(mem_rsp_valid_i && (out_cnt == '0) && (drop_q == '0)));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a latency-programmable in-order memory and
// PC model run alongside a linear sequence of checked steps.
module tb_instr_fetch;
    import ifetch_pkg::*;

    localparam logic [31:0] MASK = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pc_i = CODE_START;
    logic        pc_advance_o;
    logic        redirect_i = 1'b0;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b1;
    logic [31:0] mem_req_addr_o;
    logic        mem_rsp_valid_i = 1'b0;
    logic [31:0] mem_rsp_data_i = '0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b1;
    logic [31:0] inst_o, inst_pc_o;
    logic        inst_fault_o;

    instr_fetch #(.XLEN(32), .QDEPTH(4), .MAX_OUT(2)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pc_i            (pc_i),
        .pc_advance_o    (pc_advance_o),
        .redirect_i      (redirect_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .inst_valid_o    (inst_valid_o),
        .inst_ready_i    (inst_ready_i),
        .inst_o          (inst_o),
        .inst_pc_o       (inst_pc_o),
        .inst_fault_o    (inst_fault_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t       mem_q[$];
    logic [31:0] log_pc[$];
    int          edge_n = 0;
    int          lat = 1;
    int          acc_cnt = 0;
    logic [31:0] redir_tgt = '0;
    int          n_vec = 0;
    int          n_bad = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Memory + PC environment: respond in order after lat edges, follow pc_advance/redirect.
    initial begin
        logic [31:0] pc_nxt;
        logic        upd;
        forever begin
            @(negedge clk);
            if (mem_q.size() > 0 && mem_q[0].due <= edge_n + 1) begin
                mem_rsp_valid_i = 1'b1;
                mem_rsp_data_i  = mem_q[0].addr ^ MASK;
            end else begin
                mem_rsp_valid_i = 1'b0;
                mem_rsp_data_i  = '0;
            end
            #4;
            if (mem_rsp_valid_i && mem_q.size() > 0) void'(mem_q.pop_front());
            if (reset_n && mem_req_valid_o && mem_req_ready_i) begin
                mem_q.push_back('{addr: mem_req_addr_o, due: edge_n + 1 + lat});
                acc_cnt++;
            end
            if (reset_n && inst_valid_o && inst_ready_i && !redirect_i) log_pc.push_back(inst_pc_o);
            pc_nxt = redirect_i ? redir_tgt : (pc_advance_o ? pc_i + PC_STEP : pc_i);
            upd = reset_n;
            @(posedge clk);
            #1;
            if (upd) pc_i = pc_nxt;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Returns at the negedge where reset is released (cycle c0), before the #2 settle.
    task automatic do_reset(input logic [31:0] pc0, input int l, input logic rdy, input logic irdy);
        @(negedge clk);
        reset_n = 1'b0; pc_i = pc0; redirect_i = 1'b0; lat = l;
        mem_req_ready_i = rdy; inst_ready_i = irdy;
        mem_q.delete(); log_pc.delete(); acc_cnt = 0;
        @(negedge clk);
        #2;
        chk("rst_req_valid", 32'(mem_req_valid_o), 0);
        chk("rst_pc_adv",    32'(pc_advance_o),    0);
        chk("rst_inst_valid",32'(inst_valid_o),    0);
        chk("rst_inst",      inst_o,               0);
        chk("rst_inst_pc",   inst_pc_o,            0);
        chk("rst_fault",     32'(inst_fault_o),    0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_first(input string tag, input logic [31:0] exp);
        int n = 0;
        while (log_pc.size() == 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        #2;
        chk(tag, (log_pc.size() != 0) ? log_pc[0] : 32'hxxxx_xxxx, exp);
    endtask

    initial begin
        // Streaming fetch with single-cycle memory.
        do_reset(CODE_START, 1, 1'b1, 1'b1);
        #2;
        chk("c0_req_valid", 32'(mem_req_valid_o), 1);
        chk("c0_req_addr",  mem_req_addr_o,       32'h8000);
        chk("c0_pc_adv",    32'(pc_advance_o),    1);
        chk("c0_inst_valid",32'(inst_valid_o),    0);
        @(negedge clk); #2;
        chk("c1_no_bypass", 32'(inst_valid_o),    0);
        chk("c1_req_addr",  mem_req_addr_o,       32'h8004);
        @(negedge clk); #2;
        chk("c2_inst_valid",32'(inst_valid_o),    1);
        chk("c2_inst_pc",   inst_pc_o,            32'h8000);
        chk("c2_inst",      inst_o,               32'h8000 ^ MASK);
        @(negedge clk); #2;
        chk("c3_inst_pc",   inst_pc_o,            32'h8004);
        @(negedge clk); #2;
        chk("c4_inst_pc",   inst_pc_o,            32'h8008);
        chk("c4_inst",      inst_o,               32'h8008 ^ MASK);

        // Decode stalled: credits cap issue at QDEPTH.
        do_reset(CODE_START, 1, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        #2;
        chk("stall_acc_cnt",   32'(acc_cnt),         4);
        chk("stall_req_valid", 32'(mem_req_valid_o), 0);
        chk("stall_head_pc",   inst_pc_o,            32'h8000);
        inst_ready_i = 1'b1;
        @(negedge clk); #2;
        chk("resume_req_valid",32'(mem_req_valid_o), 1);
        chk("resume_req_addr", mem_req_addr_o,       32'h8010);
        chk("resume_first_pc", (log_pc.size() != 0) ? log_pc[0] : 32'hxxxx_xxxx, 32'h8000);

        // Memory not ready: request held stable.
        do_reset(CODE_START, 1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            #2;
            chk("hold_valid",  32'(mem_req_valid_o), 1);
            chk("hold_addr",   mem_req_addr_o,       32'h8000);
            chk("hold_pc_adv", 32'(pc_advance_o),    0);
        end
        mem_req_ready_i = 1'b1;
        @(negedge clk); #2;
        chk("hold_acc_cnt",  32'(acc_cnt),    1);
        chk("hold_next_addr",mem_req_addr_o,  32'h8004);

        // Redirect with two requests in flight, latency 3.
        do_reset(CODE_START, 3, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        redir_tgt = 32'h9000; redirect_i = 1'b1;
        #2;
        chk("rd_cycle_valid",  32'(mem_req_valid_o), 0);
        @(negedge clk);
        redirect_i = 1'b0;
        #2;
        chk("drop2_valid",     32'(mem_req_valid_o), 0);
        chk("drop2_inst_valid",32'(inst_valid_o),    0);
        @(negedge clk); #2;
        chk("drop1_valid",     32'(mem_req_valid_o), 0);
        chk("drop1_inst_valid",32'(inst_valid_o),    0);
        @(negedge clk); #2;
        chk("drop0_valid",     32'(mem_req_valid_o), 1);
        chk("drop0_addr",      mem_req_addr_o,       32'h9000);
        wait_first("redir_first_pc", 32'h9000);

        // Redirect coinciding with a response and a decode handshake, latency 2.
        do_reset(CODE_START, 2, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        redir_tgt = 32'hA000; redirect_i = 1'b1;
        #2;
        chk("co_pre_inst_valid",32'(inst_valid_o),    1);
        chk("co_pre_inst_pc",   inst_pc_o,            32'h8000);
        chk("co_req_masked",    32'(mem_req_valid_o), 0);
        @(negedge clk);
        redirect_i = 1'b0;
        #2;
        chk("co_q_empty",       32'(inst_valid_o),    0);
        chk("co_req_valid",     32'(mem_req_valid_o), 1);
        chk("co_req_addr",      mem_req_addr_o,       32'hA000);
        wait_first("co_first_pc", 32'hA000);

`ifdef IFETCH_ALIGN_CHECK_EN
        // Misaligned PC becomes a queued fault; redirect clears it.
        do_reset(32'h8002, 1, 1'b1, 1'b0);
        #2;
        chk("al_c0_valid",      32'(mem_req_valid_o), 0);
        chk("al_c0_inst_valid", 32'(inst_valid_o),    0);
        @(negedge clk); #2;
        chk("al_fault",         32'(inst_fault_o),    1);
        chk("al_fault_pc",      inst_pc_o,            32'h8002);
        chk("al_fault_inst",    inst_o,               0);
        chk("al_c1_valid",      32'(mem_req_valid_o), 0);
        @(negedge clk);
        redir_tgt = CODE_START; redirect_i = 1'b1;
        #2;
        chk("al_halted_valid",  32'(mem_req_valid_o), 0);
        @(negedge clk);
        redirect_i = 1'b0;
        #2;
        chk("al_resume_valid",  32'(mem_req_valid_o), 1);
        chk("al_resume_addr",   mem_req_addr_o,       32'h8000);
        chk("al_resume_fault",  32'(inst_fault_o),    0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
